// File: rtl/div_chain_ctrl_pkg.sv
// Shared definitions for the divide-by-2 chain controller.
//   - FSM state encoding
//   - default chain depth / select width / counter width
//   - tap-select clamp helper
package div_chain_ctrl_pkg;

    localparam int unsigned DEF_STAGES = 4;
    localparam int unsigned DEF_SEL_W  = 2;
    localparam int unsigned DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRun      = 2'd1,
        StStopping = 2'd2
    } state_e;

    // Requests beyond the last stage select the slowest tap.
    function automatic int unsigned clamp_tap(input int unsigned sel, input int unsigned stages);
        return (sel >= stages) ? stages - 1 : sel;
    endfunction

endpackage

// File: rtl/div_chain_stages.sv
// Cascade of divide-by-2 toggle stages forming a synchronous binary up-counter.
// Ports:
//   clk     system clock
//   CLR_n   asynchronous active-low reset
//   en      chain advances when high
//   clr     synchronous clear of every stage (wins over en)
//   T_out   per-stage toggle enables
//   stage_q current stage states
module div_chain_stages #(
    parameter int unsigned STAGES = 4
) (
    input  logic              clk,
    input  logic              CLR_n,
    input  logic              en,
    input  logic              clr,
    output logic [STAGES-1:0] T_out,
    output logic [STAGES-1:0] stage_q
);

    // Stage k toggles when enabled and every lower stage is high.
    always_comb begin
        logic carry;
        T_out = '0;
        carry = en;
        for (int unsigned k = 0; k < STAGES; k++) begin
            T_out[k] = carry;
            carry    = carry & stage_q[k];
        end
    end

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            stage_q <= '0;
        end else if (clr) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_q ^ T_out;
        end
    end

endmodule

// File: rtl/div_chain_ctrl.sv
// Sequencing controller for a divide-by-2 chain: runs bursts or free-runs,
// and defers tap changes to a full-chain wrap so Q never glitches.
// Ports:
//   clk, CLR_n         clock, asynchronous active-low reset
//   start, stop        run control pulses
//   burst_len          periods per run (0 = free-run), sampled on accepted start
//   sel_in, sel_req    tap change request
//   sel_ack            pulse in the first cycle the new tap is in use
//   T_out, stage_q     chain toggle enables and state
//   Q                  selected tap
//   busy, done         run status; done pulses in the first idle cycle after a run
module div_chain_ctrl
    import div_chain_ctrl_pkg::*;
#(
    parameter int unsigned STAGES = DEF_STAGES,
    parameter int unsigned SEL_W  = DEF_SEL_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              CLR_n,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic              sel_req,
    output logic              sel_ack,
    output logic [STAGES-1:0] T_out,
    output logic [STAGES-1:0] stage_q,
    output logic              Q,
    output logic              busy,
    output logic              done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_cur_q, sel_cur_d;
    logic [SEL_W-1:0] sel_pend_q, sel_pend_d;
    logic [SEL_W-1:0] sel_clamped;
    logic             pend_q, pend_d;
    logic             ack_q, ack_d;
    logic             done_q, done_d;
    logic             running, wrap, full_wrap, chain_clr;

    div_chain_stages #(
        .STAGES (STAGES)
    ) u_stages (
        .clk     (clk),
        .CLR_n   (CLR_n),
        .en      (running),
        .clr     (chain_clr),
        .T_out   (T_out),
        .stage_q (stage_q)
    );

    assign running     = (state_q != StIdle);
    assign full_wrap   = running & (&stage_q);
    assign sel_clamped = SEL_W'(clamp_tap(32'(sel_in), STAGES));

    // Wrap of the selected tap: every stage up to and including sel_cur is high.
    always_comb begin
        wrap = running;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (k <= 32'(sel_cur_q)) begin
                wrap = wrap & stage_q[k];
            end
        end
    end

    // Run sequencing and period counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        chain_clr = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = burst_len;
                end
            end
            StRun: begin
                if (wrap) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                    if (cnt_q == CNT_W'(1) || stop) begin
                        state_d   = StIdle;
                        cnt_d     = '0;
                        chain_clr = 1'b1;
                        done_d    = 1'b1;
                    end
                end else if (stop) begin
                    state_d = StStopping;
                end
            end
            StStopping: begin
                if (wrap) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    chain_clr = 1'b1;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                chain_clr = 1'b1;
            end
        endcase
    end

    // Tap select: immediate when idle, otherwise held until the whole chain wraps.
    always_comb begin
        sel_cur_d  = sel_cur_q;
        sel_pend_d = sel_pend_q;
        pend_d     = pend_q;
        ack_d      = 1'b0;
        if (!running) begin
            if (sel_req) begin
                sel_cur_d = sel_clamped;
                pend_d    = 1'b0;
                ack_d     = 1'b1;
            end else if (pend_q) begin
                sel_cur_d = sel_pend_q;
                pend_d    = 1'b0;
                ack_d     = 1'b1;
            end
        end else begin
            if (pend_q && full_wrap) begin
                sel_cur_d = sel_pend_q;
                pend_d    = 1'b0;
                ack_d     = 1'b1;
            end
            // A request landing on the apply cycle waits for the next wrap.
            if (sel_req) begin
                sel_pend_d = sel_clamped;
                pend_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sel_cur_q  <= '0;
            sel_pend_q <= '0;
            pend_q     <= 1'b0;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_cur_q  <= sel_cur_d;
            sel_pend_q <= sel_pend_d;
            pend_q     <= pend_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
        end
    end

    assign Q       = stage_q[sel_cur_q];
    assign busy    = running;
    assign done    = done_q;
    assign sel_ack = ack_q;

endmodule

// File: tb/tb_div_chain_ctrl.sv
// Bench for div_chain_ctrl: directed scenarios plus random traffic, all outputs
// compared every cycle against an arithmetic model of the chain.
module tb_div_chain_ctrl;

    localparam int STAGES = 4;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 8;
    localparam int MOD    = 1 << STAGES;

    logic              clk = 1'b0;
    logic              CLR_n = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              sel_req = 1'b0;
    logic [SEL_W-1:0]  sel_in = '0;
    logic [CNT_W-1:0]  burst_len = '0;
    logic              sel_ack, Q, busy, done;
    logic [STAGES-1:0] T_out, stage_q;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: chain is an integer count; run status as flags.
    int m_chain, m_busy, m_stopping, m_cnt, m_sel, m_pend, m_psel, m_done, m_ack;

    always #5 clk = ~clk;

    div_chain_ctrl #(
        .STAGES (STAGES),
        .SEL_W  (SEL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .CLR_n     (CLR_n),
        .start     (start),
        .stop      (stop),
        .burst_len (burst_len),
        .sel_in    (sel_in),
        .sel_req   (sel_req),
        .sel_ack   (sel_ack),
        .T_out     (T_out),
        .stage_q   (stage_q),
        .Q         (Q),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s at cycle %0d: got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_chain = 0; m_busy = 0; m_stopping = 0; m_cnt = 0;
        m_sel = 0; m_pend = 0; m_psel = 0; m_done = 0; m_ack = 0;
    endtask

    task automatic model_edge(input int st, input int sp, input int sr, input int si,
                              input int bl);
        int was_busy, tap_wrap, all_ones, leave, cl;
        was_busy = m_busy;
        tap_wrap = was_busy && (((m_chain + 1) % (1 << (m_sel + 1))) == 0);
        all_ones = was_busy && (m_chain == MOD - 1);
        cl       = (si >= STAGES) ? STAGES - 1 : si;
        leave    = 0;
        m_done   = 0;
        m_ack    = 0;
        if (!was_busy) begin
            if (st != 0) begin
                m_busy = 1; m_stopping = 0; m_cnt = bl;
            end
        end else begin
            if (tap_wrap && m_stopping != 0) begin
                leave = 1;
            end else if (tap_wrap) begin
                if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) leave = 1;
                end
                if (sp != 0) leave = 1;
            end else if (sp != 0) begin
                m_stopping = 1;
            end
            m_chain = leave ? 0 : (m_chain + 1) % MOD;
            if (leave) begin
                m_busy = 0; m_stopping = 0; m_cnt = 0; m_done = 1;
            end
        end
        if (!was_busy) begin
            if (sr != 0) begin
                m_sel = cl; m_pend = 0; m_ack = 1;
            end else if (m_pend != 0) begin
                m_sel = m_psel; m_pend = 0; m_ack = 1;
            end
        end else begin
            if (m_pend != 0 && all_ones) begin
                m_sel = m_psel; m_pend = 0; m_ack = 1;
            end
            if (sr != 0) begin
                m_psel = cl; m_pend = 1;
            end
        end
    endtask

    task automatic check_all();
        int exp_t;
        exp_t = m_busy ? ((m_chain ^ (m_chain + 1)) & (MOD - 1)) : 0;
        chk("stage_q", int'(stage_q), m_chain);
        chk("Q", int'(Q), (m_chain >> m_sel) & 1);
        chk("busy", int'(busy), m_busy);
        chk("T_out", int'(T_out), exp_t);
        chk("done", int'(done), m_done);
        chk("sel_ack", int'(sel_ack), m_ack);
    endtask

    task automatic step(input int st, input int sp, input int sr, input int si, input int bl);
        start     = (st != 0);
        stop      = (sp != 0);
        sel_req   = (sr != 0);
        sel_in    = SEL_W'(si);
        burst_len = CNT_W'(bl);
        @(posedge clk);
        model_edge(st, sp, sr, si, bl);
        #1;
        start = 1'b0; stop = 1'b0; sel_req = 1'b0;
        cyc++;
        check_all();
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && busy; i++) idle_step();
        chk("wait_idle", int'(busy), 0);
    endtask

    initial begin
        int n, highs, rises, falls, acks, qprev;
        model_reset();

        // Power-on reset.
        #1 CLR_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        CLR_n = 1'b1;

        // Bounded burst on tap 1: three 4-cycle periods.
        step(0, 0, 1, 1, 0);
        chk("idle_ack_sel1", int'(sel_ack), 1);
        step(1, 0, 0, 0, 3);
        n = 0; highs = 0; rises = 0; qprev = 0;
        while (busy && n < 40) begin
            n++;
            if (Q) highs++;
            if (Q && !qprev) rises++;
            qprev = int'(Q);
            idle_step();
        end
        chk("burst_busy_cycles", n, 12);
        chk("burst_high_cycles", highs, 6);
        chk("burst_rises", rises, 3);
        chk("burst_done", int'(done), 1);
        chk("burst_chain_zero", int'(stage_q), 0);
        idle_step();
        chk("burst_done_single", int'(done), 0);

        // Free-run on tap 0, stop while Q is high.
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (20) idle_step();
        for (int i = 0; i < 4 && !Q; i++) idle_step();
        chk("stop_q_high", int'(Q), 1);
        qprev = int'(Q);
        step(0, 1, 0, 0, 0);
        falls = (qprev != 0 && !Q) ? 1 : 0;
        chk("stop_done", int'(done), 1);
        for (int i = 0; i < 6; i++) begin
            qprev = int'(Q);
            idle_step();
            if (qprev != 0 && !Q) falls++;
        end
        chk("stop_falls", falls, 1);

        // Deferred change to tap 3 while free-running.
        step(1, 0, 0, 0, 0);
        repeat (5) idle_step();
        step(0, 0, 1, 3, 0);
        n = 6;
        while (!sel_ack && n < 40) begin
            idle_step();
            n++;
        end
        chk("defer_ack_cycle", n, 16);
        chk("defer_chain_zero", int'(stage_q), 0);
        highs = 0; rises = 0; qprev = int'(Q);
        for (int i = 0; i < 32; i++) begin
            idle_step();
            if (Q) highs++;
            if (Q && qprev == 0) rises++;
            qprev = int'(Q);
        end
        chk("defer_high_cycles", highs, 16);
        chk("defer_rises", rises, 2);
        step(0, 1, 0, 0, 0);
        wait_idle();

        // Tap change in idle, then a single 8-cycle period.
        step(0, 0, 1, 2, 0);
        chk("idle_ack_sel2", int'(sel_ack), 1);
        step(1, 0, 0, 0, 1);
        n = 0;
        while (busy && n < 40) begin
            n++;
            idle_step();
        end
        chk("sel2_busy_cycles", n, 8);

        // Overwrite then clamp: one ack, tap 3.
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        repeat (3) idle_step();
        step(0, 0, 1, 7, 0);
        acks = 0;
        for (int i = 0; i < 48; i++) begin
            idle_step();
            if (sel_ack) acks++;
        end
        chk("overwrite_acks", acks, 1);
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            idle_step();
            if (Q) highs++;
        end
        chk("clamp_high_cycles", highs, 8);
        step(0, 1, 0, 0, 0);
        wait_idle();

        // Asynchronous reset mid-run with a request pending.
        step(1, 0, 0, 0, 0);
        repeat (6) idle_step();
        step(0, 0, 1, 1, 0);
        #2 CLR_n = 1'b0;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset_no_done", int'(done), 0);
            chk("reset_idle", int'(busy), 0);
        end
        CLR_n = 1'b1;
        repeat (3) idle_step();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 8) == 0, ($urandom % 20) == 0, ($urandom % 10) == 0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 4)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
